// File: rtl/gray_pkg.sv
// Shared types and width-parameterised Gray/binary helpers for the Gray step checker.
package gray_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        RELOCK   = 2'd2
    } state_e;

    localparam int GMAXW = 32;

    function automatic logic [GMAXW-1:0] gray2bin(input logic [GMAXW-1:0] g, input int w);
        logic [GMAXW-1:0] b;
        b = {GMAXW{1'b0}};
        b[w-1] = g[w-1];
        for (int i = w - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GMAXW-1:0] bin2gray(input logic [GMAXW-1:0] b, input int w);
        logic [GMAXW-1:0] mask;
        if (w >= GMAXW) begin
            mask = {GMAXW{1'b1}};
        end else begin
            mask = (GMAXW'(1'b1) << w) - GMAXW'(1'b1);
        end
        return (b ^ (b >> 1)) & mask;
    endfunction

    function automatic int popcount(input logic [GMAXW-1:0] v, input int w);
        int c;
        c = 0;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                c++;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Monitors a Gray counter stream: decodes each sample, flags illegal steps,
// reports wraps, counts errors (saturating) and tracks lock state.
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int W          = 4,
    parameter int CW         = 8,
    parameter int RELOCK_N   = 2,
    parameter int ALLOW_HOLD = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  gray_in,
    input  logic          gray_valid,
    input  logic          clear,
    output logic [W-1:0]  bin_out,
    output logic          bin_valid,
    output logic          step_err,
    output logic          wrap,
    output logic          locked,
    output logic [CW-1:0] err_count
);

    localparam int RCW = (RELOCK_N < 1) ? 1 : $clog2(RELOCK_N + 1);

    state_e          r_state;
    logic [W-1:0]    r_ref;
    logic [RCW-1:0]  r_relock;
    logic [W-1:0]    r_bin_out;
    logic            r_bin_valid;
    logic            r_step_err;
    logic            r_wrap;
    logic            r_locked;
    logic [CW-1:0]   r_err_count;

    logic [W-1:0]    w_bin;
    logic [W-1:0]    w_ref_bin;
    logic [W-1:0]    w_ref_inc;
    logic            w_step_ok;
    logic            w_hold_ok;
    logic            w_ref_max;
    logic [CW-1:0]   w_err_inc;
    logic [RCW-1:0]  w_relock_inc;

    state_e          w_nxt_state;
    logic [W-1:0]    w_nxt_ref;
    logic [RCW-1:0]  w_nxt_relock;
    logic [W-1:0]    w_nxt_bin;
    logic            w_nxt_bvalid;
    logic            w_nxt_serr;
    logic            w_nxt_wrap;
    logic [CW-1:0]   w_nxt_err;

    assign w_bin        = W'(gray2bin(GMAXW'(gray_in), W));
    assign w_ref_bin    = W'(gray2bin(GMAXW'(r_ref), W));
    assign w_ref_inc    = w_ref_bin + W'(1'b1);
    // A legal step needs both a single-bit change and a true binary +1.
    assign w_step_ok    = (popcount(GMAXW'(gray_in ^ r_ref), W) == 32'sd1) && (w_bin == w_ref_inc);
    assign w_hold_ok    = (gray_in == r_ref) && (ALLOW_HOLD != 32'sd0);
    assign w_ref_max    = (w_ref_bin == {W{1'b1}});
    assign w_err_inc    = (r_err_count == {CW{1'b1}}) ? r_err_count : (r_err_count + CW'(1'b1));
    assign w_relock_inc = r_relock + RCW'(1'b1);

    // Next-state and step-check logic; clear outranks a sample in the same cycle.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_ref    = r_ref;
        w_nxt_relock = r_relock;
        w_nxt_bin    = r_bin_out;
        w_nxt_bvalid = 1'b0;
        w_nxt_serr   = 1'b0;
        w_nxt_wrap   = 1'b0;
        w_nxt_err    = r_err_count;
        if (clear) begin
            w_nxt_state  = UNLOCKED;
            w_nxt_err    = {CW{1'b0}};
            w_nxt_relock = {RCW{1'b0}};
        end else if (gray_valid) begin
            w_nxt_ref    = gray_in;
            w_nxt_bin    = w_bin;
            w_nxt_bvalid = 1'b1;
            case (r_state)
                UNLOCKED: begin
                    w_nxt_state  = LOCKED;
                    w_nxt_relock = {RCW{1'b0}};
                end
                LOCKED: begin
                    if (w_step_ok) begin
                        w_nxt_wrap = w_ref_max;
                    end else if (w_hold_ok) begin
                        w_nxt_wrap = 1'b0;
                    end else begin
                        w_nxt_serr   = 1'b1;
                        w_nxt_err    = w_err_inc;
                        w_nxt_relock = {RCW{1'b0}};
                        w_nxt_state  = RELOCK;
                    end
                end
                RELOCK: begin
                    if (w_step_ok) begin
                        w_nxt_wrap = w_ref_max;
                        if (w_relock_inc == RCW'(RELOCK_N)) begin
                            w_nxt_state  = LOCKED;
                            w_nxt_relock = {RCW{1'b0}};
                        end else begin
                            w_nxt_relock = w_relock_inc;
                        end
                    end else if (w_hold_ok) begin
                        w_nxt_wrap = 1'b0;
                    end else begin
                        w_nxt_serr   = 1'b1;
                        w_nxt_err    = w_err_inc;
                        w_nxt_relock = {RCW{1'b0}};
                    end
                end
                default: begin
                    w_nxt_state  = UNLOCKED;
                    w_nxt_relock = {RCW{1'b0}};
                end
            endcase
        end else begin
            w_nxt_bvalid = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= UNLOCKED;
            r_ref       <= {W{1'b0}};
            r_relock    <= {RCW{1'b0}};
            r_bin_out   <= {W{1'b0}};
            r_bin_valid <= 1'b0;
            r_step_err  <= 1'b0;
            r_wrap      <= 1'b0;
            r_locked    <= 1'b0;
            r_err_count <= {CW{1'b0}};
        end else begin
            r_state     <= w_nxt_state;
            r_ref       <= w_nxt_ref;
            r_relock    <= w_nxt_relock;
            r_bin_out   <= w_nxt_bin;
            r_bin_valid <= w_nxt_bvalid;
            r_step_err  <= w_nxt_serr;
            r_wrap      <= w_nxt_wrap;
            r_locked    <= (w_nxt_state == LOCKED);
            r_err_count <= w_nxt_err;
        end
    end

    assign bin_out   = r_bin_out;
    assign bin_valid = r_bin_valid;
    assign step_err  = r_step_err;
    assign wrap      = r_wrap;
    assign locked    = r_locked;
    assign err_count = r_err_count;

endmodule
